// File: rtl/ctrl_pkg.sv
// Shared definitions for the P2 hardwired control sequencer: opcode values,
// 4-bit step encoding and the instruction classes produced by ctrl_decoder.
// Optional feature macro: CTRL_MULDIV_EN (adds the mul/div execute sequence).
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_BRX  = 5'b10010;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        CL_NOP    = 4'd0,
        CL_ALU    = 4'd1,
        CL_LD     = 4'd2,
        CL_LDI    = 4'd3,
        CL_ST     = 4'd4,
        CL_BR     = 4'd5,
        CL_IN     = 4'd6,
        CL_OUT    = 4'd7,
        CL_MFHI   = 4'd8,
        CL_MFLO   = 4'd9,
        CL_MULDIV = 4'd10,
        CL_HALT   = 4'd11
    } instr_class_t;

    // Classes whose whole execute phase is the single T3 step.
    function automatic logic ends_at_t3(input instr_class_t cls);
        logic done;
        case (cls)
            CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP: done = 1'b1;
            default:                                 done = 1'b0;
        endcase
        return done;
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode-to-instruction-class decode for control_sequencer.
// With CTRL_MULDIV_EN undefined, mul/div opcodes fall into the nop class.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output instr_class_t   iclass
);

    // Map each opcode onto the execute sequence it uses.
    always_comb begin
        iclass = CL_NOP;
        case (opcode)
            OP_LD:                  iclass = CL_LD;
            OP_LDI:                 iclass = CL_LDI;
            OP_ST:                  iclass = CL_ST;
            OP_ADD, OP_AND, OP_OR:  iclass = CL_ALU;
`ifdef CTRL_MULDIV_EN
            OP_MUL, OP_DIV:         iclass = CL_MULDIV;
`endif
            OP_BRX:                 iclass = CL_BR;
            OP_IN:                  iclass = CL_IN;
            OP_OUT:                 iclass = CL_OUT;
            OP_MFHI:                iclass = CL_MFHI;
            OP_MFLO:                iclass = CL_MFLO;
            OP_HALT:                iclass = CL_HALT;
            default:                iclass = CL_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the P2 datapath. Steps RESET -> T0..T7 -> T0,
// one step per clock, and decodes the control strobes combinationally from
// the current step and IR[31:27]. Optional macro: CTRL_MULDIV_EN adds the
// MUL/DIV outputs and the mul/div execute sequence.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        BranchMet,
    output logic        Run,
    output logic        PCout,
    output logic        Zhiout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        OutPortin,
    output logic        Rin,
    output logic        CONIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        ReadIn,
`ifdef CTRL_MULDIV_EN
    output logic        MUL,
    output logic        DIV,
`endif
    output logic        ADD,
    output logic        AND,
    output logic        OR
);

    state_t          state_r;
    state_t          next_state_s;
    instr_class_t    iclass_s;
    logic [OPW-1:0]  opcode_s;
    logic            unused_ir_s;

    assign opcode_s    = IR[31 -: OPW];
    assign unused_ir_s = ^IR[31-OPW:0];
    assign ReadIn      = 1'b0;

    ctrl_decoder #(.OPW(OPW)) u_decoder (
        .opcode (opcode_s),
        .iclass (iclass_s)
    );

    // Step register; Clear forces RESET immediately from any step.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_r <= S_RESET;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next step: fetch is fixed, execute length depends on instruction class.
    always_comb begin
        next_state_s = S_RESET;
        case (state_r)
            S_RESET: next_state_s = S_T0;
            S_T0:    next_state_s = S_T1;
            S_T1:    next_state_s = S_T2;
            S_T2:    next_state_s = S_T3;
            S_T3: begin
                if (iclass_s == CL_HALT) begin
                    next_state_s = S_HALT;
                end else if (ends_at_t3(iclass_s)) begin
                    next_state_s = S_T0;
                end else begin
                    next_state_s = S_T4;
                end
            end
            S_T4:    next_state_s = S_T5;
            S_T5: begin
                case (iclass_s)
                    CL_ALU, CL_LDI: next_state_s = S_T0;
                    default:        next_state_s = S_T6;
                endcase
            end
            S_T6: begin
                case (iclass_s)
                    CL_LD, CL_ST: next_state_s = S_T7;
                    default:      next_state_s = S_T0;
                endcase
            end
            S_T7:    next_state_s = S_T0;
            S_HALT:  next_state_s = S_HALT;
            default: next_state_s = S_RESET;
        endcase
    end

    // Strobe decode from step and instruction class; everything defaults low.
    always_comb begin
        Run = 1'b0;       PCout = 1'b0;     Zhiout = 1'b0;    Zlowout = 1'b0;
        MDRout = 1'b0;    HIout = 1'b0;     LOout = 1'b0;     InPortout = 1'b0;
        Cout = 1'b0;      BAout = 1'b0;     Rout = 1'b0;      MARin = 1'b0;
        Zin = 1'b0;       PCin = 1'b0;      MDRin = 1'b0;     IRin = 1'b0;
        Yin = 1'b0;       HIin = 1'b0;      LOin = 1'b0;      OutPortin = 1'b0;
        Rin = 1'b0;       CONIn = 1'b0;     Gra = 1'b0;       Grb = 1'b0;
        Grc = 1'b0;       IncPC = 1'b0;     Read = 1'b0;      Write = 1'b0;
        ADD = 1'b0;       AND = 1'b0;       OR = 1'b0;
`ifdef CTRL_MULDIV_EN
        MUL = 1'b0;       DIV = 1'b0;
`endif
        case (state_r)
            S_RESET, S_HALT: Run = 1'b0;
            S_T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
            end
            S_T1: begin
                Run = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            S_T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                Run = 1'b1;
                case (iclass_s)
                    CL_ALU:              begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    CL_LD, CL_LDI, CL_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    CL_BR:               begin Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1; end
                    CL_IN:               begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_OUT:              begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    CL_MFHI:             begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_MFLO:             begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef CTRL_MULDIV_EN
                    CL_MULDIV:           begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
                    default:             Run = 1'b1;
                endcase
            end
            S_T4: begin
                Run = 1'b1;
                case (iclass_s)
                    CL_ALU: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        if (opcode_s == OP_AND) begin
                            AND = 1'b1;
                        end else if (opcode_s == OP_OR) begin
                            OR = 1'b1;
                        end else begin
                            ADD = 1'b1;
                        end
                    end
                    CL_LD, CL_LDI, CL_ST: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                    CL_BR:                begin PCout = 1'b1; Yin = 1'b1; end
`ifdef CTRL_MULDIV_EN
                    CL_MULDIV: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        if (opcode_s == OP_DIV) begin
                            DIV = 1'b1;
                        end else begin
                            MUL = 1'b1;
                        end
                    end
`endif
                    default: Run = 1'b1;
                endcase
            end
            S_T5: begin
                Run = 1'b1;
                case (iclass_s)
                    CL_ALU, CL_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_LD, CL_ST:   begin Zlowout = 1'b1; MARin = 1'b1; end
                    CL_BR:          begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
`ifdef CTRL_MULDIV_EN
                    CL_MULDIV:      begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
                    default:        Run = 1'b1;
                endcase
            end
            S_T6: begin
                Run = 1'b1;
                case (iclass_s)
                    CL_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    CL_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    CL_BR: begin
                        if (BranchMet) begin
                            Zlowout = 1'b1; PCin = 1'b1;
                        end else begin
                            Zlowout = 1'b0; PCin = 1'b0;
                        end
                    end
`ifdef CTRL_MULDIV_EN
                    CL_MULDIV: begin Zhiout = 1'b1; HIin = 1'b1; end
`endif
                    default: Run = 1'b1;
                endcase
            end
            S_T7: begin
                Run = 1'b1;
                case (iclass_s)
                    CL_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    CL_ST:   Write = 1'b1;
                    default: Run = 1'b1;
                endcase
            end
            default: Run = 1'b0;
        endcase
    end

endmodule
